// File: rtl/mem_pkg.sv
// Shared types for the wait-state memory: FSM states, opcode encoding, wait bound, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

   // Controller states; ready is high only in IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Captured request opcode.
   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Largest legal WAIT_CYCLES and the counter width that holds it.
   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = $clog2(WAIT_MAX + 1);

   // Even parity: the returned bit makes the total count of ones (byte + bit) even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage : mem_pkg

// File: rtl/wait_state_memory_if.sv
// Request/response bus of the wait-state memory; master issues requests, slave is the memory.
// Latency: n/a (wiring only).
// Backpressure: ready from the slave; requests seen while ready is low are dropped, not queued.
// Ports: memread/memwrite/address/data_in/byte_en (request), ready/valid/data_out/err (response),
//        plus parity_err when MAIN_MEM_PARITY_EN is defined.
interface wait_state_memory_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 17
);
   logic                  memread;
   logic                  memwrite;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     data_in;
   logic [DATA_W/8-1:0]   byte_en;
   logic                  ready;
   logic                  valid;
   logic [DATA_W-1:0]     data_out;
   logic                  err;
`ifdef MAIN_MEM_PARITY_EN
   logic                  parity_err;
`endif

   modport master (
      output memread, memwrite, address, data_in, byte_en,
`ifdef MAIN_MEM_PARITY_EN
      input  parity_err,
`endif
      input  ready, valid, data_out, err
   );

   modport slave (
      input  memread, memwrite, address, data_in, byte_en,
`ifdef MAIN_MEM_PARITY_EN
      output parity_err,
`endif
      output ready, valid, data_out, err
   );

endinterface : wait_state_memory_if

// File: rtl/mem_array.sv
// Word storage with per-lane write enables and a registered read port; contents are never reset.
// Latency: write lands on the enabling edge; read data appears one edge after rd_en.
// Backpressure: none; accepts a read and a write every cycle.
// Ports: clk; wr_en/wr_lane/wr_addr/wr_data (write); rd_en/rd_addr/rd_data (read).
module mem_array #(
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [LANES-1:0]              wr_lane,
   input  logic [IDX_W-1:0]              wr_addr,
   input  logic [LANES-1:0][LANE_W-1:0]  wr_data,
   input  logic                          rd_en,
   input  logic [IDX_W-1:0]              rd_addr,
   output logic [LANES-1:0][LANE_W-1:0]  rd_data
);

   logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_lane[i]) begin
               mem[wr_addr][i] <= wr_data[i];
            end
         end
      end
      // rd_data holds its value until the next enabled read.
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule : mem_array

// File: rtl/wait_state_memory.sv
// Single-outstanding memory with WAIT_CYCLES of added latency; optional per-byte parity (MAIN_MEM_PARITY_EN).
// Latency: request accepted at edge T completes with a one-cycle valid pulse in cycle T+WAIT_CYCLES+1.
// Backpressure: ready only in IDLE; requests outside IDLE are ignored, minimum spacing WAIT_CYCLES+2.
// Ports: clk, rst (async, active-high), bus (slave modport: request in, ready/valid/data_out/err out).
module wait_state_memory
   import mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 17,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   wait_state_memory_if.slave    bus
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MAIN_MEM_PARITY_EN
   localparam int LANE_W = 9;   // {parity, byte}
`else
   localparam int LANE_W = 8;
`endif

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Request captured at acceptance.
   op_t                  op_q;
   logic                 bad_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_W-1:0]    wdat_q;
   logic [NB-1:0]        ben_q;

   logic                 valid_q;
   logic                 err_q;
   logic [DATA_W-1:0]    dout_q;

   logic                 req, accept, reject;
   logic                 misaligned, out_of_range;
   logic [ADDR_W-1:0]    word_idx;
   logic                 rd_en, wr_en;
   logic                 resp_err;
   logic [DATA_W-1:0]    rd_word;
   logic [NB-1:0][LANE_W-1:0] arr_wdat, arr_rdat;

   assign req          = bus.memread | bus.memwrite;
   assign accept       = (state_q == IDLE) & req;
   assign word_idx     = bus.address >> OFF_W;
   assign misaligned   = (bus.address & ADDR_W'(NB - 1)) != '0;
   // One extra bit so DEPTH == 2**ADDR_W cannot wrap the compare.
   assign out_of_range = {1'b0, word_idx} >= (ADDR_W + 1)'(DEPTH);
   assign reject       = misaligned | out_of_range | (bus.memread & bus.memwrite);

   // Read is launched at acceptance so the registered array output is ready by RESP,
   // including the zero-wait case where RESP immediately follows acceptance.
   assign rd_en = accept & bus.memread & ~reject;
   assign wr_en = (state_q == RESP) & (op_q == OP_WR) & ~bad_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= bus.memwrite ? OP_WR : OP_RD;
         bad_q  <= reject;
         idx_q  <= word_idx[IDX_W-1:0];
         wdat_q <= bus.data_in;
         ben_q  <= bus.byte_en;
      end
   end

   always_comb begin
      for (int i = 0; i < NB; i++) begin
`ifdef MAIN_MEM_PARITY_EN
         arr_wdat[i] = {even_parity(wdat_q[8*i +: 8]), wdat_q[8*i +: 8]};
`else
         arr_wdat[i] = wdat_q[8*i +: 8];
`endif
      end
   end

`ifdef MAIN_MEM_PARITY_EN
   logic par_bad;
   logic par_hit;
   logic perr_q;
`endif

   always_comb begin
      rd_word = '0;
`ifdef MAIN_MEM_PARITY_EN
      par_bad = 1'b0;
`endif
      for (int i = 0; i < NB; i++) begin
         rd_word[8*i +: 8] = arr_rdat[i][7:0];
`ifdef MAIN_MEM_PARITY_EN
         par_bad = par_bad | (arr_rdat[i][8] != even_parity(arr_rdat[i][7:0]));
`endif
      end
   end

`ifdef MAIN_MEM_PARITY_EN
   // Parity is only meaningful for a read that actually touched the array.
   assign par_hit  = (op_q == OP_RD) & ~bad_q & par_bad;
   assign resp_err = bad_q | par_hit;
`else
   assign resp_err = bad_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
`ifdef MAIN_MEM_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= (state_q == RESP);
         err_q   <= (state_q == RESP) & resp_err;
`ifdef MAIN_MEM_PARITY_EN
         perr_q  <= (state_q == RESP) & par_hit;
`endif
         // Rejected reads leave data_out untouched; parity-failed reads still return the data.
         if ((state_q == RESP) && (op_q == OP_RD) && !bad_q) begin
            dout_q <= rd_word;
         end
      end
   end

   mem_array #(
      .LANES  (NB),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_lane (ben_q),
      .wr_addr (idx_q),
      .wr_data (arr_wdat),
      .rd_en   (rd_en),
      .rd_addr (word_idx[IDX_W-1:0]),
      .rd_data (arr_rdat)
   );

   assign bus.ready    = (state_q == IDLE);
   assign bus.valid    = valid_q;
   assign bus.err      = err_q;
   assign bus.data_out = dout_q;
`ifdef MAIN_MEM_PARITY_EN
   assign bus.parity_err = perr_q;
`endif

endmodule : wait_state_memory

// File: doc/wait_state_memory.md
WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; multiple of 8.
REQ-002 Parameter ADDR_W, default 17, byte address width.
REQ-003 Parameter DEPTH, default 1024, number of words; DEPTH*(DATA_W/8) SHALL NOT exceed 2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 2, added access latency; range 0..15.
REQ-005 clk  input  1  single clock; all state on the rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 memread  input  1  read request.
REQ-008 memwrite  input  1  write request.
REQ-009 address  input  ADDR_W  byte address.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 byte_en  input  DATA_W/8  per-byte write enable.
REQ-012 ready  output  1  high when a request is accepted this cycle.
REQ-013 valid  output  1  one-cycle completion pulse for both reads and writes.
REQ-014 data_out  output  DATA_W  read data; held between read completions.
REQ-015 err  output  1  qualified by valid; access was rejected.

Function
REQ-016 FSM states are IDLE, WAIT and RESP; ready SHALL equal (state==IDLE).
REQ-017 In IDLE, memread|memwrite SHALL capture address, data_in, byte_en and the opcode, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES==0).
REQ-018 WAIT SHALL load a down-counter with WAIT_CYCLES-1, decrement it each cycle, and move to RESP at 0.
REQ-019 RESP SHALL perform the access, assert valid for exactly one cycle, and return to IDLE; a request accepted at edge T completes with valid high in cycle T+WAIT_CYCLES+1.
REQ-020 Requests presented outside IDLE SHALL be ignored, with no queueing.
REQ-021 Word index = address[ADDR_W-1:log2(DATA_W/8)].
REQ-022 Write SHALL update only the bytes whose byte_en bit is 1; byte_en==0 is a legal no-op that completes with err=0.
REQ-023 Read SHALL load data_out with the full stored word at RESP.
REQ-024 The following SHALL set err=1 with no array access and data_out unchanged: misaligned address (low byte bits nonzero); word index >= DEPTH; memread and memwrite both high at acceptance.
REQ-025 Back-to-back requests: the next request is accepted in the IDLE cycle following RESP, so minimum spacing is WAIT_CYCLES+2 cycles.
REQ-026 A read after a write to the same word SHALL return the written data.

Reset
REQ-027 rst SHALL force state=IDLE, counter=0, valid=0, err=0 and data_out=0 immediately, aborting any in-flight access; an aborted write SHALL NOT modify the array.
REQ-028 Array contents SHALL NOT be reset.

Configuration
REQ-029 With MAIN_MEM_PARITY_EN defined: one even-parity bit per byte is stored on write; read parity is checked at RESP; a mismatch sets err=1 while still returning the data; an added output parity_err (1 bit) pulses with valid.
REQ-030 Without MAIN_MEM_PARITY_EN: no parity storage, no parity_err port, and err is driven only per REQ-024.

Structure
REQ-031 A shared package mem_pkg SHALL hold the FSM state enum, the opcode encoding (RD/WR), and the WAIT_CYCLES bound constant.
REQ-032 The storage array SHALL be a sub-module mem_array: synchronous write with byte enables, read data registered, no reset.

Verification
REQ-033 WAIT_CYCLES=2: write 0xDEADBEEF to address 0x100 with byte_en=0xF at edge T -> valid at T+3 with err=0; then read 0x100 -> data_out=0xDEADBEEF.
REQ-034 Write 0x000000AA with byte_en=0x1 over 0xDEADBEEF at 0x100, then read 0x100 -> 0xDEADBEAA.
REQ-035 Read address 0x102 -> valid with err=1 and data_out unchanged; read address DEPTH*4 -> err=1.
REQ-036 memread=memwrite=1 -> err=1 and array unchanged; a request held during WAIT -> not accepted (ready=0).
REQ-037 Assert rst during WAIT of a write to 0x200 -> outputs 0 immediately; a later read of 0x200 returns the prior content.
REQ-038 WAIT_CYCLES=0 build: read accepted at T -> valid at T+1; with MAIN_MEM_PARITY_EN, a forced stored-parity flip -> parity_err=1 and err=1.
